// File: rtl/dbg_tx_arbiter_pkg.sv
// Shared types, constants and ASCII helpers for the debug transmit arbiter.
//   state_t      : arbiter FSM states
//   xfer_t       : latched payload of the granted command unit
//   nib_to_ascii : one hex nibble to its ASCII character
//   char_at      : character k of a latched payload
package dbg_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic TYPE_BYTE = 1'b0;
  localparam logic TYPE_WORD = 1'b1;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_a = 8'h61;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned WORD_CHARS = 8;
  localparam int unsigned IDX_W      = 3;

  typedef struct packed {
    logic              typ;
    logic [WORD_W-1:0] word;
  } xfer_t;

  // Hex nibble to ASCII, upper or lower case letters.
  function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib, input logic upper);
    if (nib < 4'd10)
      return ASCII_0 + 8'(nib);
    else if (upper)
      return ASCII_A + 8'(nib - 4'd10);
    else
      return ASCII_a + 8'(nib - 4'd10);
  endfunction

  // Character idx of a payload: raw low byte, or nibble idx counted from the MSB.
  function automatic logic [7:0] char_at(input logic [WORD_W-1:0] word, input logic typ,
                                         input logic [IDX_W-1:0] idx, input logic upper);
    logic [4:0] sh;
    logic [3:0] nib;
    sh  = 5'd28 - {idx, 2'b00};
    nib = 4'(word >> sh);
    if (typ == TYPE_BYTE)
      return word[7:0];
    return nib_to_ascii(nib, upper);
  endfunction

endpackage

// File: rtl/dbg_tx_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req          : request vector
//   ptr          : index searched first
//   mask         : eligibility mask (all ones when no lock owner is active)
//   grant_c      : one-hot grant
//   grant_idx_c  : index of the granted requester
//   grant_vld_c  : a requester was granted
module rr_arbiter #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  input  logic [N_REQ-1:0] mask,
  output logic [N_REQ-1:0] grant_c,
  output logic [IW-1:0]    grant_idx_c,
  output logic             grant_vld_c
);

  // First eligible requester at or after ptr, wrapping at N_REQ-1.
  always_comb begin
    logic [N_REQ-1:0] elig;
    int unsigned      j;
    elig        = req & mask;
    j           = 0;
    grant_c     = '0;
    grant_idx_c = '0;
    grant_vld_c = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      j = (32'(ptr) + i) % N_REQ;
      if (!grant_vld_c && elig[IW'(j)]) begin
        grant_vld_c        = 1'b1;
        grant_c[IW'(j)]    = 1'b1;
        grant_idx_c        = IW'(j);
      end
    end
  end

endmodule

// File: rtl/dbg_tx_arbiter.sv
// Shares the serial transmitter between debug command units. Grants one
// requester, streams its payload as ASCII bytes on a valid/ready port and
// pulses ack_tx to that requester. A locking requester keeps ownership
// across consecutive requests so multi-message printouts never interleave.
//   clk, rst  : clock, synchronous active-high reset
//   req_tx    : per-unit request, held until ack
//   type_tx   : per-unit payload type (0 raw byte, 1 hex word)
//   lock_tx   : per-unit ownership lock
//   dout_tx   : concatenated 32-bit payloads, unit i at [32i+31:32i]
//   ack_tx    : one-cycle completion pulse to the granted unit
//   tx_data, tx_vld, tx_rdy : byte stream to the UART transmitter
//   busy      : arbiter not idle
//   grant_id  : current or last granted unit
module dbg_tx_arbiter
  import dbg_tx_pkg::*;
#(
  parameter  int unsigned N_REQ     = 4,
  parameter  int unsigned HEX_UPPER = 1,
  localparam int unsigned IW        = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_tx,
  input  logic [N_REQ-1:0]      type_tx,
  input  logic [N_REQ-1:0]      lock_tx,
  input  logic [WORD_W*N_REQ-1:0] dout_tx,
  output logic [N_REQ-1:0]      ack_tx,
  output logic [7:0]            tx_data,
  output logic                  tx_vld,
  input  logic                  tx_rdy,
  output logic                  busy,
  output logic [IW-1:0]         grant_id
);

  localparam logic UPPER = (HEX_UPPER != 0);

  state_t             state;
  xfer_t              xfer_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      owner_q;
  logic               owner_vld_q;

  logic               lock_act_c;
  logic [N_REQ-1:0]   mask_c;
  logic [N_REQ-1:0]   win_c;
  logic [IW-1:0]      win_idx_c;
  logic               win_vld_c;
  logic               win_typ_c;
  logic               win_lock_c;
  logic [WORD_W-1:0]  win_word_c;
  logic               last_c;

  // An active lock restricts eligibility to the owner alone.
  assign lock_act_c = owner_vld_q && lock_tx[owner_q];
  assign mask_c     = lock_act_c ? (N_REQ'(1) << owner_q) : '1;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req         (req_tx),
    .ptr         (ptr_q),
    .mask        (mask_c),
    .grant_c     (win_c),
    .grant_idx_c (win_idx_c),
    .grant_vld_c (win_vld_c)
  );

  assign win_typ_c  = |(type_tx & win_c);
  assign win_lock_c = |(lock_tx & win_c);
  assign win_word_c = dout_tx[{win_idx_c, 5'd0} +: WORD_W];
  assign last_c     = (xfer_q.typ == TYPE_BYTE) || (idx_q == IDX_W'(WORD_CHARS - 1));

  // Arbiter FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ack_tx      <= '0;
      tx_vld      <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      grant_id    <= '0;
      ptr_q       <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      xfer_q      <= '0;
      idx_q       <= '0;
    end else begin
      ack_tx <= '0;
      case (state)
        IDLE: begin
          // A lock dropped while idle releases ownership before arbitration.
          if (owner_vld_q && !lock_tx[owner_q])
            owner_vld_q <= 1'b0;
          if (win_vld_c) begin
            xfer_q      <= '{typ: win_typ_c, word: win_word_c};
            grant_id    <= win_idx_c;
            idx_q       <= '0;
            tx_data     <= char_at(win_word_c, win_typ_c, '0, UPPER);
            tx_vld      <= 1'b1;
            busy        <= 1'b1;
            owner_q     <= win_idx_c;
            owner_vld_q <= win_lock_c;
            ptr_q       <= (win_idx_c == IW'(N_REQ - 1)) ? '0 : win_idx_c + IW'(1);
            state       <= SEND;
          end
        end
        SEND: begin
          if (tx_rdy) begin
            if (last_c) begin
              tx_vld <= 1'b0;
              ack_tx <= N_REQ'(1) << grant_id;
              state  <= ACK;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              tx_data <= char_at(xfer_q.word, xfer_q.typ, idx_q + IDX_W'(1), UPPER);
            end
          end
        end
        ACK: begin
          state <= HOLD;
        end
        HOLD: begin
          // Requests are ignored here so the just-acked unit's stale req is dropped.
          if (owner_vld_q && !lock_tx[owner_q])
            owner_vld_q <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
